cc_branch_unit: RTL and testbench

CC_BRANCH_UNIT -- requirements
Module: cc_branch_unit

---
 rtl/cc_branch_unit.sv | 101 ++++++++++
 tb/tb_cc_branch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cc_branch_unit.sv
// Branch resolution unit: condition-code register, IDLE/EVAL/RESP handshake FSM and a taken counter.
// Optional CC_FORWARD_EN: a request accepted while load_cc=1 evaluates against cc_in rather than cc_q.
module cc_branch_unit (
    input  logic        clock,
    input  logic        reset_L,
    input  logic [3:0]  cc_in,
    input  logic        load_cc,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_pc,
    input  logic [15:0] br_offset,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_taken,
    output logic [15:0] resp_target,
    output logic [3:0]  cc_q,
    output logic [7:0]  taken_count
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t      state, state_nx;
    logic        accept, release_resp;
    logic [2:0]  cond_q;
    logic [15:0] pc_q, off_q;
    logic [3:0]  snap_q, snap_d;
    logic        taken;

    always_ff @(posedge clock) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (br_valid)   state_nx = EVAL;
            EVAL:                    state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_comb begin
        br_ready     = (state == IDLE);
        resp_valid   = (state == RESP);
        accept       = br_ready && br_valid;
        release_resp = resp_valid && resp_ready;
    end

`ifdef CC_FORWARD_EN
    assign snap_d = load_cc ? cc_in : cc_q;
`else
    assign snap_d = cc_q;
`endif

    // Snapshot bit order is {Z,C,N,V}.
    always_comb begin
        taken = 1'b0;
        case (cond_q)
            3'b000: taken = 1'b1;
            3'b001: taken = snap_q[3];
            3'b010: taken = !snap_q[3];
            3'b011: taken = snap_q[2];
            3'b100: taken = snap_q[1];
            3'b101: taken = snap_q[0];
            3'b110: taken = snap_q[1] ^ snap_q[0];
            3'b111: taken = !(snap_q[1] ^ snap_q[0]);
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            cc_q        <= 4'b0000;
            taken_count <= 8'h00;
            cond_q      <= 3'b000;
            pc_q        <= 16'h0000;
            off_q       <= 16'h0000;
            snap_q      <= 4'b0000;
            resp_taken  <= 1'b0;
            resp_target <= 16'h0000;
        end else begin
            if (load_cc) cc_q <= cc_in;
            if (accept) begin
                cond_q <= br_cond;
                pc_q   <= br_pc;
                off_q  <= br_offset;
                snap_q <= snap_d;
            end
            if (state == EVAL) begin
                resp_taken  <= taken;
                resp_target <= taken ? (pc_q + off_q) : (pc_q + 16'd2);
            end
            if (release_resp && resp_taken && taken_count != 8'hFF)
                taken_count <= taken_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_cc_branch_unit.sv
// Directed bench for cc_branch_unit: a vector table of condition/target cases plus
// sequences for cc forwarding, response backpressure, counter saturation and mid-flight reset.
module tb_cc_branch_unit;

    logic        clock = 1'b0;
    logic        reset_L, load_cc, br_valid, resp_ready;
    logic [3:0]  cc_in;
    logic [2:0]  br_cond;
    logic [15:0] br_pc, br_offset;
    logic        br_ready, resp_valid, resp_taken;
    logic [15:0] resp_target;
    logic [3:0]  cc_q;
    logic [7:0]  taken_count;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_cnt = 8'h00;

    cc_branch_unit dut (
        .clock(clock), .reset_L(reset_L), .cc_in(cc_in), .load_cc(load_cc),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_pc(br_pc),
        .br_offset(br_offset), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_taken(resp_taken), .resp_target(resp_target), .cc_q(cc_q),
        .taken_count(taken_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  cc;
        logic [2:0]  cond;
        logic [15:0] pc;
        logic [15:0] off;
        logic        taken;
        logic [15:0] target;
    } vec_t;

    vec_t vt[14];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [3:0] v);
        cc_in = v; load_cc = 1'b1;
        tick();
        load_cc = 1'b0;
        chk("cc_q_load", 32'(cc_q), 32'(v));
    endtask

    // Accept on the first edge, EVAL after it, RESP after the second edge.
    task automatic start_req(input logic [2:0] c, input logic [15:0] p, input logic [15:0] o);
        int w;
        br_cond = c; br_pc = p; br_offset = o; br_valid = 1'b1;
        chk("br_ready_idle", 32'(br_ready), 32'(1));
        tick();
        br_valid = 1'b0; load_cc = 1'b0;
        chk("eval_resp_valid", 32'(resp_valid), 32'(0));
        chk("eval_br_ready", 32'(br_ready), 32'(0));
        tick();
        chk("latency2_resp_valid", 32'(resp_valid), 32'(1));
        w = 0;
        while (!resp_valid && w < 4) begin
            tick();
            w++;
        end
    endtask

    task automatic finish_req(input logic exp_taken);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        if (exp_taken && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        chk("post_hs_resp_valid", 32'(resp_valid), 32'(0));
        chk("post_hs_br_ready", 32'(br_ready), 32'(1));
        chk("taken_count", 32'(taken_count), 32'(exp_cnt));
    endtask

    task automatic check_resp(input logic t, input logic [15:0] tgt);
        chk("resp_taken", 32'(resp_taken), 32'(t));
        chk("resp_target", 32'(resp_target), 32'(tgt));
    endtask

    initial begin
        logic        fwd_taken;
        logic [15:0] fwd_target;

        vt[0]  = '{4'b1000, 3'b001, 16'h0010, 16'h0008, 1'b1, 16'h0018};
        vt[1]  = '{4'b0000, 3'b001, 16'hFFFE, 16'h0008, 1'b0, 16'h0000};
        vt[2]  = '{4'b0010, 3'b110, 16'h0100, 16'hFFF0, 1'b1, 16'h00F0};
        vt[3]  = '{4'b0010, 3'b111, 16'h0100, 16'hFFF0, 1'b0, 16'h0102};
        vt[4]  = '{4'b0000, 3'b000, 16'h1234, 16'h0100, 1'b1, 16'h1334};
        vt[5]  = '{4'b0000, 3'b010, 16'h2000, 16'h0040, 1'b1, 16'h2040};
        vt[6]  = '{4'b0100, 3'b011, 16'h3000, 16'hFFFE, 1'b1, 16'h2FFE};
        vt[7]  = '{4'b1011, 3'b011, 16'h3000, 16'h0010, 1'b0, 16'h3002};
        vt[8]  = '{4'b0010, 3'b100, 16'h4000, 16'h0004, 1'b1, 16'h4004};
        vt[9]  = '{4'b0001, 3'b101, 16'h5000, 16'h0006, 1'b1, 16'h5006};
        vt[10] = '{4'b0011, 3'b110, 16'h6000, 16'h0020, 1'b0, 16'h6002};
        vt[11] = '{4'b0001, 3'b111, 16'h7000, 16'h0030, 1'b0, 16'h7002};
        vt[12] = '{4'b1000, 3'b010, 16'h8000, 16'h0002, 1'b0, 16'h8002};
        vt[13] = '{4'b0111, 3'b001, 16'hFFF0, 16'h0020, 1'b0, 16'hFFF2};

        reset_L = 1'b0; load_cc = 1'b1; cc_in = 4'b1111; br_valid = 1'b1;
        resp_ready = 1'b1; br_cond = 3'b000; br_pc = 16'h0; br_offset = 16'h0;
        tick();
        tick();
        chk("rst_cc_q", 32'(cc_q), 32'(0));
        chk("rst_taken_count", 32'(taken_count), 32'(0));
        chk("rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_br_ready", 32'(br_ready), 32'(1));
        chk("rst_resp_taken", 32'(resp_taken), 32'(0));
        chk("rst_resp_target", 32'(resp_target), 32'(0));
        load_cc = 1'b0; br_valid = 1'b0; resp_ready = 1'b0;
        reset_L = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            load(vt[i].cc);
            start_req(vt[i].cond, vt[i].pc, vt[i].off);
            check_resp(vt[i].taken, vt[i].target);
            finish_req(vt[i].taken);
        end

        // Condition codes written on the accept edge itself.
        load(4'b0000);
        cc_in = 4'b1000; load_cc = 1'b1;
`ifdef CC_FORWARD_EN
        fwd_taken = 1'b1; fwd_target = 16'h0208;
`else
        fwd_taken = 1'b0; fwd_target = 16'h0202;
`endif
        start_req(3'b001, 16'h0200, 16'h0008);
        check_resp(fwd_taken, fwd_target);
        chk("fwd_cc_q", 32'(cc_q), 32'(4'b1000));
        finish_req(fwd_taken);

        // Backpressure: response held, new requests ignored, cc_q still loadable.
        start_req(3'b001, 16'h0010, 16'h0008);
        for (int k = 0; k < 5; k++) begin
            br_valid = 1'b1; br_cond = 3'b010; br_pc = 16'hAAAA; br_offset = 16'h5555;
            load_cc = (k == 2); cc_in = 4'b0101;
            tick();
            chk("hold_resp_valid", 32'(resp_valid), 32'(1));
            chk("hold_br_ready", 32'(br_ready), 32'(0));
            check_resp(1'b1, 16'h0018);
        end
        br_valid = 1'b0; load_cc = 1'b0;
        chk("hold_cc_q", 32'(cc_q), 32'(4'b0101));
        finish_req(1'b1);
        check_resp(1'b1, 16'h0018);

        // Saturation of the taken counter.
        for (int k = 0; k < 256; k++) begin
            start_req(3'b000, 16'(k), 16'h0004);
            finish_req(1'b1);
        end
        chk("sat_taken_count", 32'(taken_count), 32'(8'hFF));

        // Reset while a request sits in EVAL.
        load(4'b1100);
        br_valid = 1'b1; br_cond = 3'b000; br_pc = 16'h0400; br_offset = 16'h0010;
        tick();
        br_valid = 1'b0;
        chk("pre_rst_eval", 32'(br_ready), 32'(0));
        reset_L = 1'b0;
        tick();
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("mid_rst_br_ready", 32'(br_ready), 32'(1));
        chk("mid_rst_cc_q", 32'(cc_q), 32'(0));
        chk("mid_rst_taken_count", 32'(taken_count), 32'(0));
        chk("mid_rst_resp_target", 32'(resp_target), 32'(0));
        reset_L = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_resp", 32'(resp_valid), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
